// File: rtl/axi_rarb_pkg.sv
// Shared types and helpers for the AXI4 read-path arbiter.
// Build option AXI_RARB_TIMEOUT_EN enables the R-beat watchdog (TOUT state) in axi_read_arbiter.
package axi_rarb_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAddr = 2'd1,
    StData = 2'd2,
    StTout = 2'd3
  } rarb_state_e;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  // Width of an index into n requesters; never narrower than one bit.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_read_arbiter_if.sv
// AR/R bus bundle for axi_read_arbiter: packed per-master request side plus the shared slave side.
// Modports: arb (the arbiter), master (requesters' view), slave (downstream slave mux view).
interface axi_read_arbiter_if #(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned ID_WIDTH    = 1
);

  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_ARADDR;
  logic [NUM_MASTERS*ID_WIDTH-1:0]   m_ARID;
  logic [NUM_MASTERS*8-1:0]          m_ARLEN;
  logic [NUM_MASTERS*3-1:0]          m_ARSIZE;
  logic [NUM_MASTERS*2-1:0]          m_ARBURST;
  logic [NUM_MASTERS-1:0]            m_ARVALID;
  logic [NUM_MASTERS-1:0]            m_ARREADY;
  logic [ID_WIDTH-1:0]               m_RID;
  logic [DATA_WIDTH-1:0]             m_RDATA;
  logic [1:0]                        m_RRESP;
  logic                              m_RLAST;
  logic [NUM_MASTERS-1:0]            m_RVALID;
  logic [NUM_MASTERS-1:0]            m_RREADY;

  logic [ADDR_WIDTH-1:0]             s_ARADDR;
  logic [ID_WIDTH-1:0]               s_ARID;
  logic [7:0]                        s_ARLEN;
  logic [2:0]                        s_ARSIZE;
  logic [1:0]                        s_ARBURST;
  logic                              s_ARVALID;
  logic                              s_ARREADY;
  logic [ID_WIDTH-1:0]               s_RID;
  logic [DATA_WIDTH-1:0]             s_RDATA;
  logic [1:0]                        s_RRESP;
  logic                              s_RLAST;
  logic                              s_RVALID;
  logic                              s_RREADY;

  modport arb (
    input  m_ARADDR, m_ARID, m_ARLEN, m_ARSIZE, m_ARBURST, m_ARVALID, m_RREADY,
    output m_ARREADY, m_RID, m_RDATA, m_RRESP, m_RLAST, m_RVALID,
    output s_ARADDR, s_ARID, s_ARLEN, s_ARSIZE, s_ARBURST, s_ARVALID, s_RREADY,
    input  s_ARREADY, s_RID, s_RDATA, s_RRESP, s_RLAST, s_RVALID
  );

  modport master (
    output m_ARADDR, m_ARID, m_ARLEN, m_ARSIZE, m_ARBURST, m_ARVALID, m_RREADY,
    input  m_ARREADY, m_RID, m_RDATA, m_RRESP, m_RLAST, m_RVALID
  );

  modport slave (
    input  s_ARADDR, s_ARID, s_ARLEN, s_ARSIZE, s_ARBURST, s_ARVALID, s_RREADY,
    output s_ARREADY, s_RID, s_RDATA, s_RRESP, s_RLAST, s_RVALID
  );

endinterface

// File: rtl/axi_rr_picker.sv
// Combinational round-robin picker: first set request scanning upward from last_i+1 with wrap.
// Output is one-hot, or zero when no request is set.
module axi_rr_picker
  import axi_rarb_pkg::*;
#(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdxW   = idx_width(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   last_i,
  output logic [NumReq-1:0] pick_o
);

  logic            found;
  logic [IdxW-1:0] idx;
  int unsigned     pos;

  always_comb begin
    pick_o = '0;
    found  = 1'b0;
    idx    = '0;
    pos    = 0;
    for (int unsigned off = 1; off <= NumReq; off++) begin
      pos = (32'(last_i) + off) % NumReq;
      idx = IdxW'(pos);
      if (!found && req_i[idx]) begin
        pick_o[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// Round-robin arbiter sharing one AXI4 read path; grant held from AR handshake to RLAST handshake.
// Define AXI_RARB_TIMEOUT_EN to add the R-beat watchdog that answers a stuck burst with SLVERR.
module axi_read_arbiter
  import axi_rarb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 4,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned ID_WIDTH       = 1,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                   ACLK,
  input  logic                   ARESETn,
  axi_read_arbiter_if.arb        bus,
  output logic [NUM_MASTERS-1:0] grant_o,
  output logic                   busy_o
);

  localparam int unsigned IdxW = idx_width(NUM_MASTERS);

  rarb_state_e            state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IdxW-1:0]        last_q, last_d;
  logic [IdxW-1:0]        owner;
  logic [NUM_MASTERS-1:0] pick;

  logic                   s_arvalid;
  logic [ADDR_WIDTH-1:0]  s_araddr;
  logic [ID_WIDTH-1:0]    s_arid;
  logic [7:0]             s_arlen;
  logic [2:0]             s_arsize;
  logic [1:0]             s_arburst;
  logic                   s_rready;
  logic [NUM_MASTERS-1:0] m_arready;
  logic [NUM_MASTERS-1:0] m_rvalid;
  logic [ID_WIDTH-1:0]    m_rid;
  logic [DATA_WIDTH-1:0]  m_rdata;
  logic [1:0]             m_rresp;
  logic                   m_rlast;

`ifdef AXI_RARB_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WdW-1:0]      wd_q, wd_d;
  logic [ID_WIDTH-1:0] arid_q, arid_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  axi_rr_picker #(
    .NumReq (NUM_MASTERS),
    .IdxW   (IdxW)
  ) u_picker (
    .req_i  (bus.m_ARVALID),
    .last_i (last_q),
    .pick_o (pick)
  );

  // Owner index decoded from the registered one-hot grant only.
  always_comb begin
    owner = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q[i]) owner = IdxW'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    s_arvalid = 1'b0;
    s_araddr  = '0;
    s_arid    = '0;
    s_arlen   = '0;
    s_arsize  = '0;
    s_arburst = '0;
    s_rready  = 1'b0;
    m_arready = '0;
    m_rvalid  = '0;
    m_rid     = '0;
    m_rdata   = '0;
    m_rresp   = RespOkay;
    m_rlast   = 1'b0;
`ifdef AXI_RARB_TIMEOUT_EN
    wd_d      = wd_q;
    arid_d    = arid_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (|bus.m_ARVALID) begin
          grant_d = pick;
          state_d = StAddr;
        end
      end
      StAddr: begin
        s_arvalid = bus.m_ARVALID[owner];
        s_araddr  = bus.m_ARADDR[owner*ADDR_WIDTH +: ADDR_WIDTH];
        s_arid    = bus.m_ARID[owner*ID_WIDTH +: ID_WIDTH];
        s_arlen   = bus.m_ARLEN[owner*8 +: 8];
        s_arsize  = bus.m_ARSIZE[owner*3 +: 3];
        s_arburst = bus.m_ARBURST[owner*2 +: 2];
        m_arready = grant_q & {NUM_MASTERS{bus.s_ARREADY}};
        if (s_arvalid && bus.s_ARREADY) begin
          state_d = StData;
`ifdef AXI_RARB_TIMEOUT_EN
          wd_d    = '0;
          arid_d  = s_arid;
`endif
        end
      end
      StData: begin
        s_rready = bus.m_RREADY[owner];
        m_rvalid = grant_q & {NUM_MASTERS{bus.s_RVALID}};
        m_rid    = bus.s_RID;
        m_rdata  = bus.s_RDATA;
        m_rresp  = bus.s_RRESP;
        m_rlast  = bus.s_RLAST;
        if (bus.s_RVALID && s_rready && bus.s_RLAST) begin
          state_d = StIdle;
          last_d  = owner;
          grant_d = '0;
        end
`ifdef AXI_RARB_TIMEOUT_EN
        else if (bus.s_RVALID && s_rready) begin
          wd_d = '0;
        end else begin
          wd_d = wd_q + 1'b1;
          if (wd_d == WdW'(TIMEOUT_CYCLES)) state_d = StTout;
        end
`endif
      end
`ifdef AXI_RARB_TIMEOUT_EN
      // Synthesised error response; the slave's late beats are left unacknowledged.
      StTout: begin
        m_rvalid = grant_q;
        m_rresp  = RespSlverr;
        m_rlast  = 1'b1;
        m_rid    = arid_q;
        if (bus.m_RREADY[owner]) begin
          state_d = StIdle;
          last_d  = owner;
          grant_d = '0;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= StIdle;
      grant_q <= '0;
      last_q  <= IdxW'(NUM_MASTERS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

`ifdef AXI_RARB_TIMEOUT_EN
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wd_q   <= '0;
      arid_q <= '0;
    end else begin
      wd_q   <= wd_d;
      arid_q <= arid_d;
    end
  end
`endif

  assign bus.s_ARVALID = s_arvalid;
  assign bus.s_ARADDR  = s_araddr;
  assign bus.s_ARID    = s_arid;
  assign bus.s_ARLEN   = s_arlen;
  assign bus.s_ARSIZE  = s_arsize;
  assign bus.s_ARBURST = s_arburst;
  assign bus.s_RREADY  = s_rready;
  assign bus.m_ARREADY = m_arready;
  assign bus.m_RVALID  = m_rvalid;
  assign bus.m_RID     = m_rid;
  assign bus.m_RDATA   = m_rdata;
  assign bus.m_RRESP   = m_rresp;
  assign bus.m_RLAST   = m_rlast;

  assign grant_o = grant_q;
  assign busy_o  = (state_q != StIdle);

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed self-checking bench for axi_read_arbiter (4 masters, 32-bit data/address, 1-bit ID).
// The timeout scenario runs only when AXI_RARB_TIMEOUT_EN is defined (TIMEOUT_CYCLES = 16).
module tb_axi_read_arbiter;

  logic       ACLK = 1'b0;
  logic       ARESETn;
  logic [3:0] grant_o;
  logic       busy_o;
  int         n_checks = 0;
  int         n_pass = 0;

  always #5 ACLK = ~ACLK;

  axi_read_arbiter_if #(
    .NUM_MASTERS (4),
    .DATA_WIDTH  (32),
    .ADDR_WIDTH  (32),
    .ID_WIDTH    (1)
  ) bus ();

  axi_read_arbiter #(
    .NUM_MASTERS    (4),
    .DATA_WIDTH     (32),
    .ADDR_WIDTH     (32),
    .ID_WIDTH       (1),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .bus     (bus),
    .grant_o (grant_o),
    .busy_o  (busy_o)
  );

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    bus.m_ARADDR  = '0;
    bus.m_ARID    = '0;
    bus.m_ARLEN   = '0;
    bus.m_ARSIZE  = '0;
    bus.m_ARBURST = '0;
    bus.m_ARVALID = '0;
    bus.m_RREADY  = '0;
    bus.s_ARREADY = 1'b0;
    bus.s_RID     = '0;
    bus.s_RDATA   = '0;
    bus.s_RRESP   = '0;
    bus.s_RLAST   = 1'b0;
    bus.s_RVALID  = 1'b0;
  endtask

  task automatic pulse_reset();
    idle_inputs();
    ARESETn = 1'b0;
    step();
    ARESETn = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    ARESETn = 1'b0;
    #3;
    n_checks++; if (bus.s_ARVALID !== 1'b0) $display("FAIL rst_s_arvalid got %b want 0", bus.s_ARVALID); else n_pass++;
    n_checks++; if (bus.s_RREADY !== 1'b0) $display("FAIL rst_s_rready got %b want 0", bus.s_RREADY); else n_pass++;
    n_checks++; if (bus.m_ARREADY !== 4'b0) $display("FAIL rst_m_arready got %b want 0000", bus.m_ARREADY); else n_pass++;
    n_checks++; if (bus.m_RVALID !== 4'b0) $display("FAIL rst_m_rvalid got %b want 0000", bus.m_RVALID); else n_pass++;
    n_checks++; if (grant_o !== 4'b0) $display("FAIL rst_grant got %b want 0000", grant_o); else n_pass++;
    n_checks++; if (busy_o !== 1'b0) $display("FAIL rst_busy got %b want 0", busy_o); else n_pass++;
    n_checks++; if (bus.s_ARADDR !== 32'h0) $display("FAIL rst_s_araddr got %h want 0", bus.s_ARADDR); else n_pass++;
    n_checks++; if (bus.m_RDATA !== 32'h0) $display("FAIL rst_m_rdata got %h want 0", bus.m_RDATA); else n_pass++;
    step();
    ARESETn = 1'b1;
  endtask

  task automatic test_basic();
    bus.m_ARADDR[31:0] = 32'h100;
    bus.m_ARVALID      = 4'b0001;
    settle();
    n_checks++; if (bus.s_ARVALID !== 1'b0) $display("FAIL basic_no_early_ar got %b want 0", bus.s_ARVALID); else n_pass++;
    step();
    n_checks++; if (bus.s_ARVALID !== 1'b1) $display("FAIL basic_s_arvalid got %b want 1", bus.s_ARVALID); else n_pass++;
    n_checks++; if (bus.s_ARADDR !== 32'h100) $display("FAIL basic_s_araddr got %h want 100", bus.s_ARADDR); else n_pass++;
    n_checks++; if (grant_o !== 4'b0001) $display("FAIL basic_grant got %b want 0001", grant_o); else n_pass++;
    n_checks++; if (busy_o !== 1'b1) $display("FAIL basic_busy got %b want 1", busy_o); else n_pass++;
    n_checks++; if (bus.m_ARREADY !== 4'b0) $display("FAIL basic_arready_low got %b want 0000", bus.m_ARREADY); else n_pass++;
    bus.s_ARREADY = 1'b1;
    settle();
    n_checks++; if (bus.m_ARREADY !== 4'b0001) $display("FAIL basic_arready got %b want 0001", bus.m_ARREADY); else n_pass++;
    step();
    bus.m_ARVALID = '0;
    bus.s_ARREADY = 1'b0;
    bus.s_RVALID  = 1'b1;
    bus.s_RLAST   = 1'b1;
    bus.s_RDATA   = 32'hCAFE_0100;
    bus.m_RREADY  = 4'b0001;
    settle();
    n_checks++; if (bus.m_RVALID !== 4'b0001) $display("FAIL basic_m_rvalid got %b want 0001", bus.m_RVALID); else n_pass++;
    n_checks++; if (bus.m_RDATA !== 32'hCAFE_0100) $display("FAIL basic_m_rdata got %h want cafe0100", bus.m_RDATA); else n_pass++;
    n_checks++; if (bus.s_RREADY !== 1'b1) $display("FAIL basic_s_rready got %b want 1", bus.s_RREADY); else n_pass++;
    step();
    idle_inputs();
    settle();
    n_checks++; if (busy_o !== 1'b0) $display("FAIL basic_done_busy got %b want 0", busy_o); else n_pass++;
    n_checks++; if (grant_o !== 4'b0) $display("FAIL basic_done_grant got %b want 0000", grant_o); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [31:0] exp_a [5] = '{32'h1000, 32'h2000, 32'h3000, 32'h4000, 32'h1000};
    pulse_reset();
    for (int i = 0; i < 4; i++) bus.m_ARADDR[i*32 +: 32] = 32'h1000 * (i + 1);
    bus.m_ARVALID = 4'b1111;
    bus.m_RREADY  = 4'b1111;
    step();
    for (int k = 0; k < 5; k++) begin
      n_checks++; if (grant_o !== exp_g[k]) $display("FAIL rr_grant[%0d] got %b want %b", k, grant_o, exp_g[k]); else n_pass++;
      n_checks++; if (bus.s_ARADDR !== exp_a[k]) $display("FAIL rr_addr[%0d] got %h want %h", k, bus.s_ARADDR, exp_a[k]); else n_pass++;
      bus.s_ARREADY = 1'b1;
      settle();
      n_checks++; if (bus.m_ARREADY !== exp_g[k]) $display("FAIL rr_arready[%0d] got %b want %b", k, bus.m_ARREADY, exp_g[k]); else n_pass++;
      step();
      bus.s_ARREADY = 1'b0;
      bus.s_RVALID  = 1'b1;
      bus.s_RLAST   = 1'b1;
      settle();
      n_checks++; if (bus.m_RVALID !== exp_g[k]) $display("FAIL rr_rvalid[%0d] got %b want %b", k, bus.m_RVALID, exp_g[k]); else n_pass++;
      step();
      bus.s_RVALID = 1'b0;
      bus.s_RLAST  = 1'b0;
      settle();
      n_checks++; if (bus.s_ARVALID !== 1'b0) $display("FAIL rr_bubble[%0d] got %b want 0", k, bus.s_ARVALID); else n_pass++;
      step();
      n_checks++; if (bus.s_ARVALID !== 1'b1) $display("FAIL rr_next_ar[%0d] got %b want 1", k, bus.s_ARVALID); else n_pass++;
    end
    // Requester withdraws in ADDR: AR must drop and the grant must not move.
    bus.m_ARVALID = '0;
    settle();
    n_checks++; if (bus.s_ARVALID !== 1'b0) $display("FAIL rr_withdraw_ar got %b want 0", bus.s_ARVALID); else n_pass++;
    step();
    n_checks++; if ({busy_o, grant_o} !== 5'b1_0010) $display("FAIL rr_withdraw_hold got %b want 10010", {busy_o, grant_o}); else n_pass++;
    pulse_reset();
  endtask

  task automatic test_burst();
    int beats = 0;
    bus.m_ARVALID        = 4'b0100;
    bus.m_ARLEN[16 +: 8] = 8'd3;
    step();
    n_checks++; if (grant_o !== 4'b0100) $display("FAIL burst_grant got %b want 0100", grant_o); else n_pass++;
    n_checks++; if (bus.s_ARLEN !== 8'd3) $display("FAIL burst_arlen got %0d want 3", bus.s_ARLEN); else n_pass++;
    bus.s_ARREADY = 1'b1;
    step();
    bus.m_ARVALID = '0;
    bus.s_ARREADY = 1'b0;
    for (int c = 0; c < 40 && beats < 4; c++) begin
      bus.s_RVALID = (c % 3 != 1);
      bus.s_RLAST  = (beats == 3);
      bus.s_RDATA  = 32'hA0 + 32'(beats);
      bus.m_RREADY = (c % 4 != 2) ? 4'b1111 : 4'b1011;
      settle();
      n_checks++;
      if (bus.m_RVALID !== {1'b0, bus.s_RVALID, 2'b00})
        $display("FAIL burst_rvalid_mask[%0d] got %b want %b", c, bus.m_RVALID, {1'b0, bus.s_RVALID, 2'b00});
      else n_pass++;
      if (bus.s_RVALID && bus.m_RREADY[2]) begin
        n_checks++;
        if (bus.m_RDATA !== 32'hA0 + 32'(beats))
          $display("FAIL burst_data[%0d] got %h want %h", beats, bus.m_RDATA, 32'hA0 + 32'(beats));
        else n_pass++;
        n_checks++;
        if (bus.m_RLAST !== (beats == 3))
          $display("FAIL burst_rlast[%0d] got %b want %b", beats, bus.m_RLAST, (beats == 3));
        else n_pass++;
        beats++;
      end
      step();
    end
    bus.s_RVALID = 1'b0;
    bus.s_RLAST  = 1'b0;
    settle();
    n_checks++; if (beats !== 4) $display("FAIL burst_beats got %0d want 4", beats); else n_pass++;
    n_checks++; if (busy_o !== 1'b0) $display("FAIL burst_done_busy got %b want 0", busy_o); else n_pass++;
    bus.s_RVALID = 1'b1;
    bus.s_RLAST  = 1'b1;
    settle();
    n_checks++;
    if ({bus.m_RVALID, bus.s_RREADY} !== 5'b0)
      $display("FAIL burst_late_beat got %b want 00000", {bus.m_RVALID, bus.s_RREADY});
    else n_pass++;
    idle_inputs();
  endtask

  task automatic test_mid_burst_request();
    bus.m_ARVALID       = 4'b0010;
    bus.m_ARLEN[8 +: 8] = 8'd1;
    step();
    n_checks++; if (grant_o !== 4'b0010) $display("FAIL mid_grant1 got %b want 0010", grant_o); else n_pass++;
    bus.s_ARREADY = 1'b1;
    step();
    bus.m_ARVALID = 4'b0001;
    bus.s_RVALID  = 1'b1;
    bus.s_RLAST   = 1'b0;
    bus.m_RREADY  = 4'b0010;
    settle();
    n_checks++; if (bus.m_ARREADY !== 4'b0) $display("FAIL mid_arready_beat1 got %b want 0000", bus.m_ARREADY); else n_pass++;
    n_checks++; if (grant_o !== 4'b0010) $display("FAIL mid_grant_held got %b want 0010", grant_o); else n_pass++;
    step();
    bus.s_RLAST = 1'b1;
    settle();
    n_checks++; if (bus.m_ARREADY !== 4'b0) $display("FAIL mid_arready_beat2 got %b want 0000", bus.m_ARREADY); else n_pass++;
    step();
    bus.s_RVALID = 1'b0;
    bus.s_RLAST  = 1'b0;
    settle();
    n_checks++; if (bus.m_ARREADY !== 4'b0) $display("FAIL mid_arready_idle got %b want 0000", bus.m_ARREADY); else n_pass++;
    step();
    n_checks++; if (grant_o !== 4'b0001) $display("FAIL mid_grant0 got %b want 0001", grant_o); else n_pass++;
    n_checks++; if (bus.m_ARREADY !== 4'b0001) $display("FAIL mid_arready0 got %b want 0001", bus.m_ARREADY); else n_pass++;
    step();
    bus.m_ARVALID = '0;
    bus.s_ARREADY = 1'b0;
    bus.s_RVALID  = 1'b1;
    bus.s_RLAST   = 1'b1;
    bus.m_RREADY  = 4'b0001;
    step();
    idle_inputs();
  endtask

  task automatic test_reset_mid_burst();
    bus.m_ARVALID        = 4'b1000;
    bus.m_ARLEN[24 +: 8] = 8'd3;
    step();
    n_checks++; if (grant_o !== 4'b1000) $display("FAIL rstmid_grant got %b want 1000", grant_o); else n_pass++;
    bus.s_ARREADY = 1'b1;
    step();
    bus.m_ARVALID = '0;
    bus.s_ARREADY = 1'b0;
    bus.s_RVALID  = 1'b1;
    bus.s_RDATA   = 32'h55;
    bus.m_RREADY  = 4'b1000;
    step();
    settle();
    n_checks++; if (bus.m_RVALID !== 4'b1000) $display("FAIL rstmid_beat2 got %b want 1000", bus.m_RVALID); else n_pass++;
    ARESETn = 1'b0;
    #1;
    n_checks++; if (bus.m_RVALID !== 4'b0) $display("FAIL rstmid_rvalid got %b want 0000", bus.m_RVALID); else n_pass++;
    n_checks++; if (bus.s_RREADY !== 1'b0) $display("FAIL rstmid_s_rready got %b want 0", bus.s_RREADY); else n_pass++;
    n_checks++; if (grant_o !== 4'b0) $display("FAIL rstmid_grant0 got %b want 0000", grant_o); else n_pass++;
    n_checks++; if (busy_o !== 1'b0) $display("FAIL rstmid_busy got %b want 0", busy_o); else n_pass++;
    n_checks++; if (bus.m_RDATA !== 32'h0) $display("FAIL rstmid_rdata got %h want 0", bus.m_RDATA); else n_pass++;
    idle_inputs();
    bus.m_ARVALID = 4'b1001;
    step();
    ARESETn = 1'b1;
    step();
    n_checks++; if (grant_o !== 4'b0001) $display("FAIL rstmid_prio got %b want 0001", grant_o); else n_pass++;
    pulse_reset();
  endtask

`ifdef AXI_RARB_TIMEOUT_EN
  task automatic test_timeout();
    bus.m_ARVALID = 4'b0010;
    bus.m_ARID    = 4'b0010;
    step();
    bus.s_ARREADY = 1'b1;
    step();
    bus.m_ARVALID = '0;
    bus.s_ARREADY = 1'b0;
    bus.m_RREADY  = '0;
    for (int i = 0; i < 16; i++) begin
      n_checks++; if (bus.m_RVALID !== 4'b0) $display("FAIL tout_early[%0d] got %b want 0000", i, bus.m_RVALID); else n_pass++;
      step();
    end
    n_checks++; if (bus.m_RVALID !== 4'b0010) $display("FAIL tout_rvalid got %b want 0010", bus.m_RVALID); else n_pass++;
    n_checks++; if (bus.m_RRESP !== 2'b10) $display("FAIL tout_rresp got %b want 10", bus.m_RRESP); else n_pass++;
    n_checks++; if (bus.m_RLAST !== 1'b1) $display("FAIL tout_rlast got %b want 1", bus.m_RLAST); else n_pass++;
    n_checks++; if (bus.m_RID !== 1'b1) $display("FAIL tout_rid got %b want 1", bus.m_RID); else n_pass++;
    n_checks++; if (bus.m_RDATA !== 32'h0) $display("FAIL tout_rdata got %h want 0", bus.m_RDATA); else n_pass++;
    n_checks++; if (bus.s_RREADY !== 1'b0) $display("FAIL tout_s_rready got %b want 0", bus.s_RREADY); else n_pass++;
    bus.m_RREADY = 4'b0010;
    step();
    settle();
    n_checks++; if (busy_o !== 1'b0) $display("FAIL tout_idle got %b want 0", busy_o); else n_pass++;
    idle_inputs();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_burst();
    test_mid_burst_request();
    test_reset_mid_burst();
`ifdef AXI_RARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
